// File: rtl/instr_mem_loader_pkg.sv
// Shared opcode map, instruction field positions and loader state encoding.
// The control unit decodes from the same constants, so encoder and decoder stay aligned.
package instr_mem_loader_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLTI = 6'b011011;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_BNE  = 6'b110001;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam int OP_LSB  = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int SA_LSB  = 6;
    localparam int IMM_LSB = 0;
    localparam int TGT_LSB = 0;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_WRITE = 2'd1,
        LD_DONE  = 2'd2
    } ld_state_e;

    // Big-endian byte pick: index 0 is the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Field input handshake, byte-wide memory write port and session status of the loader.
interface instr_mem_loader_if #(
    parameter int ADDR_W = 7
);
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_sa;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [ADDR_W-2:0] word_count;
    logic              load_done;
    logic              err_illegal;
    logic              err_full;

    modport master (
        output clear, in_valid, in_op, in_rs, in_rt, in_rd, in_sa, in_imm, in_target,
        input  in_ready, mem_we, mem_addr, mem_wdata, word_count, load_done,
               err_illegal, err_full
    );

    modport slave (
        input  clear, in_valid, in_op, in_rs, in_rt, in_rd, in_sa, in_imm, in_target,
        output in_ready, mem_we, mem_addr, mem_wdata, word_count, load_done,
               err_illegal, err_full
    );
endinterface

// File: rtl/instr_mem_loader_encoder.sv
// Purely combinational packing of instruction fields into a 32-bit word.
// Fields a class does not use are dropped so stray values never leak into the word.
module instr_word_encoder
    import instr_mem_loader_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_sa,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_legal,
    output logic        o_halt
);

    logic [31:0] w_op;
    logic [31:0] w_rs;
    logic [31:0] w_rt;
    logic [31:0] w_rd;
    logic [31:0] w_sa;
    logic [31:0] w_imm;
    logic [31:0] w_tgt;

    assign w_op  = 32'(i_op)     << OP_LSB;
    assign w_rs  = 32'(i_rs)     << RS_LSB;
    assign w_rt  = 32'(i_rt)     << RT_LSB;
    assign w_rd  = 32'(i_rd)     << RD_LSB;
    assign w_sa  = 32'(i_sa)     << SA_LSB;
    assign w_imm = 32'(i_imm)    << IMM_LSB;
    assign w_tgt = 32'(i_target) << TGT_LSB;

    always_comb begin
        o_word  = '0;
        o_legal = 1'b1;
        o_halt  = 1'b0;
        case (i_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR:
                o_word = w_op | w_rs | w_rt | w_rd;
            OP_SLL:
                o_word = w_op | w_rt | w_rd | w_sa;
            OP_ADDI, OP_ORI, OP_SLTI, OP_SW, OP_LW, OP_BEQ, OP_BNE:
                o_word = w_op | w_rs | w_rt | w_imm;
            OP_J:
                o_word = w_op | w_tgt;
            OP_HALT: begin
                o_word = w_op;
                o_halt = 1'b1;
            end
            default: begin
                o_word  = '0;
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Fills byte-wide instruction memory: accepts fields, encodes a word and writes it
// big-endian over four consecutive cycles, stopping at halt or when memory is full.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 7
) (
    input  logic clk,
    input  logic rst_n,
    instr_mem_loader_if.slave bus
);

    localparam int WC_W = ADDR_W - 1;
    localparam logic [1:0] ST_IDLE  = LD_IDLE;
    localparam logic [1:0] ST_WRITE = LD_WRITE;
    localparam logic [1:0] ST_DONE  = LD_DONE;
    localparam logic [ADDR_W:0] FULL_ADDR = (ADDR_W + 1)'(MEM_BYTES);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_byte_idx;
    logic [31:0]       r_word;
    logic              r_is_halt;
    logic [WC_W-1:0]   r_word_count;
    logic              r_load_done;
    logic              r_err_illegal;
    logic              r_err_full;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_halt;
    logic [1:0]        w_next_idx;
    logic [ADDR_W:0]   w_addr_plus4;

    instr_word_encoder u_enc (
        .i_op     (bus.in_op),
        .i_rs     (bus.in_rs),
        .i_rt     (bus.in_rt),
        .i_rd     (bus.in_rd),
        .i_sa     (bus.in_sa),
        .i_imm    (bus.in_imm),
        .i_target (bus.in_target),
        .o_word   (w_word),
        .o_legal  (w_legal),
        .o_halt   (w_halt)
    );

    assign w_next_idx = r_byte_idx + 2'd1;
    // One extra bit so the last slot's end address does not wrap before the full test.
    assign w_addr_plus4 = {1'b0, r_addr} + (ADDR_W + 1)'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_byte_idx    <= '0;
            r_word        <= '0;
            r_is_halt     <= 1'b0;
            r_word_count  <= '0;
            r_load_done   <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_full    <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
        end else if (bus.clear) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_byte_idx    <= '0;
            r_word_count  <= '0;
            r_load_done   <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_full    <= 1'b0;
            r_mem_we      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (w_legal) begin
                            r_word      <= w_word;
                            r_is_halt   <= w_halt;
                            r_byte_idx  <= 2'd0;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_addr;
                            r_mem_wdata <= word_byte(w_word, 2'd0);
                            r_state     <= ST_WRITE;
                        end else begin
                            r_err_illegal <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (r_byte_idx == 2'd3) begin
                        r_mem_we     <= 1'b0;
                        r_addr       <= w_addr_plus4[ADDR_W-1:0];
                        r_word_count <= r_word_count + WC_W'(1);
                        // Halt takes precedence, so halt in the final slot is not an overflow.
                        if (r_is_halt) begin
                            r_state     <= ST_DONE;
                            r_load_done <= 1'b1;
                        end else if (w_addr_plus4 == FULL_ADDR) begin
                            r_state     <= ST_DONE;
                            r_load_done <= 1'b1;
                            r_err_full  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_byte_idx  <= w_next_idx;
                        r_mem_addr  <= r_addr + ADDR_W'(w_next_idx);
                        r_mem_wdata <= word_byte(r_word, w_next_idx);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = (r_state == ST_IDLE);
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.word_count  = r_word_count;
    assign bus.load_done   = r_load_done;
    assign bus.err_illegal = r_err_illegal;
    assign bus.err_full    = r_err_full;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench: stimulus queues expected (addr, byte) pairs, monitors pop and compare
// on every memory write; status outputs are checked against hand-computed values.
module tb_instr_mem_loader;

    logic clk;
    logic rst_n;

    logic        t_sel;
    logic        t_valid;
    logic        t_clear;
    logic [5:0]  t_op;
    logic [4:0]  t_rs, t_rt, t_rd, t_sa;
    logic [15:0] t_imm;
    logic [25:0] t_tgt;

    int tests;
    int fails;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    instr_mem_loader_if #(.ADDR_W(7)) bus_a ();
    instr_mem_loader_if #(.ADDR_W(4)) bus_b ();

    instr_mem_loader #(.MEM_BYTES(128), .ADDR_W(7)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    instr_mem_loader #(.MEM_BYTES(16), .ADDR_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    assign bus_a.in_valid  = t_valid & ~t_sel;
    assign bus_b.in_valid  = t_valid &  t_sel;
    assign bus_a.clear     = t_clear & ~t_sel;
    assign bus_b.clear     = t_clear &  t_sel;
    assign bus_a.in_op     = t_op;
    assign bus_b.in_op     = t_op;
    assign bus_a.in_rs     = t_rs;
    assign bus_b.in_rs     = t_rs;
    assign bus_a.in_rt     = t_rt;
    assign bus_b.in_rt     = t_rt;
    assign bus_a.in_rd     = t_rd;
    assign bus_b.in_rd     = t_rd;
    assign bus_a.in_sa     = t_sa;
    assign bus_b.in_sa     = t_sa;
    assign bus_a.in_imm    = t_imm;
    assign bus_b.in_imm    = t_imm;
    assign bus_a.in_target = t_tgt;
    assign bus_b.in_target = t_tgt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bus_a.mem_we) begin
            logic [15:0] got;
            logic [15:0] exp;
            got = {8'(bus_a.mem_addr), bus_a.mem_wdata};
            tests++;
            if (q_a.size() == 0) begin
                fails++;
                $display("FAIL mem_write_a: got addr=%0d data=%02h, required no write", got[15:8], got[7:0]);
            end else begin
                exp = q_a.pop_front();
                if (got != exp) begin
                    fails++;
                    $display("FAIL mem_write_a: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             got[15:8], got[7:0], exp[15:8], exp[7:0]);
                end else
                    $display("[TB] A wrote addr=%0d data=%02h", got[15:8], got[7:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus_b.mem_we) begin
            logic [15:0] got;
            logic [15:0] exp;
            got = {8'(bus_b.mem_addr), bus_b.mem_wdata};
            tests++;
            if (q_b.size() == 0) begin
                fails++;
                $display("FAIL mem_write_b: got addr=%0d data=%02h, required no write", got[15:8], got[7:0]);
            end else begin
                exp = q_b.pop_front();
                if (got != exp) begin
                    fails++;
                    $display("FAIL mem_write_b: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             got[15:8], got[7:0], exp[15:8], exp[7:0]);
                end else
                    $display("[TB] B wrote addr=%0d data=%02h", got[15:8], got[7:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else
            $display("[TB] %s = %0h ok", name, act);
    endtask

    // Queue the first nbytes of a word, most significant byte first, from base address.
    task automatic push_word(input logic sel, input int addr, input logic [31:0] word, input int nbytes);
        logic [31:0] w;
        w = word;
        for (int i = 0; i < nbytes; i++) begin
            logic [15:0] e;
            e = {8'(addr + i), w[31:24]};
            w = w << 8;
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
        end
    endtask

    task automatic send(input logic sel, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                        input logic [25:0] tgt);
        int n;
        t_sel = sel; t_op = op; t_rs = rs; t_rt = rt; t_rd = rd; t_sa = sa; t_imm = imm; t_tgt = tgt;
        t_valid = 1'b1;
        n = 0;
        while (!(sel ? bus_b.in_ready : bus_a.in_ready) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 for 20 cycles, required 1 (op=%06b)", op);
        end else begin
            @(posedge clk); #1;
        end
        t_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear(input logic sel);
        t_sel = sel;
        t_clear = 1'b1;
        @(posedge clk); #1;
        t_clear = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        t_sel = 0; t_valid = 0; t_clear = 0;
        t_op = '0; t_rs = '0; t_rt = '0; t_rd = '0; t_sa = '0; t_imm = '0; t_tgt = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;

        // Reset state
        chk("rst_ready_a",   32'(bus_a.in_ready), 1);
        chk("rst_we_a",      32'(bus_a.mem_we), 0);
        chk("rst_addr_a",    32'(bus_a.mem_addr), 0);
        chk("rst_wdata_a",   32'(bus_a.mem_wdata), 0);
        chk("rst_wc_a",      32'(bus_a.word_count), 0);
        chk("rst_flags_a",   {29'd0, bus_a.load_done, bus_a.err_illegal, bus_a.err_full}, 0);
        chk("rst_ready_b",   32'(bus_b.in_ready), 1);

        // Single addi
        push_word(0, 0, 32'h04010008, 4);
        send(0, 6'b000001, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0008, 26'd0);
        wait_cycles(4);
        chk("addi_wc",    32'(bus_a.word_count), 1);
        chk("addi_ready", 32'(bus_a.in_ready), 1);
        chk("addi_done",  32'(bus_a.load_done), 0);

        // add, sll, j, halt sequence; unused fields carry junk that must be ignored
        pulse_clear(0);
        push_word(0, 0,  32'h00221800, 4);
        send(0, 6'b000000, 5'd1, 5'd2, 5'd3, 5'd9, 16'hABCD, 26'h3FFFFFF);
        push_word(0, 4,  32'h60011080, 4);
        send(0, 6'b011000, 5'd7, 5'd1, 5'd2, 5'd2, 16'hFFFF, 26'h1234567);
        push_word(0, 8,  32'hE0000004, 4);
        send(0, 6'b111000, 5'd5, 5'd6, 5'd7, 5'd8, 16'h5555, 26'h0000004);
        push_word(0, 12, 32'hFC000000, 4);
        send(0, 6'b111111, 5'd5, 5'd6, 5'd7, 5'd8, 16'h5555, 26'h2AAAAAA);
        wait_cycles(4);
        chk("halt_done",  32'(bus_a.load_done), 1);
        chk("halt_wc",    32'(bus_a.word_count), 4);
        chk("halt_ready", 32'(bus_a.in_ready), 0);
        chk("halt_full",  32'(bus_a.err_full), 0);
        t_sel = 0; t_op = 6'b000001; t_valid = 1'b1;
        wait_cycles(6);
        t_valid = 1'b0;
        chk("done_ready_hold", 32'(bus_a.in_ready), 0);
        chk("done_wc_hold",    32'(bus_a.word_count), 4);

        // Illegal opcode, then legal words from address 0
        pulse_clear(0);
        chk("clr_done", 32'(bus_a.load_done), 0);
        chk("clr_wc",   32'(bus_a.word_count), 0);
        t_sel = 0; t_op = 6'b101010; t_valid = 1'b1;
        wait_cycles(1);
        t_valid = 1'b0;
        wait_cycles(1);
        chk("illegal_flag",  32'(bus_a.err_illegal), 1);
        chk("illegal_wc",    32'(bus_a.word_count), 0);
        chk("illegal_ready", 32'(bus_a.in_ready), 1);
        push_word(0, 0, 32'h04010008, 4);
        send(0, 6'b000001, 5'd0, 5'd1, 5'd31, 5'd31, 16'h0008, 26'h3FFFFFF);
        push_word(0, 4, 32'h9843FFFC, 4);
        send(0, 6'b100110, 5'd2, 5'd3, 5'd0, 5'd0, 16'hFFFC, 26'd0);
        push_word(0, 8, 32'h48853000, 4);
        send(0, 6'b010010, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0000, 26'd0);
        wait_cycles(4);
        chk("post_illegal_wc",   32'(bus_a.word_count), 3);
        chk("illegal_sticky",    32'(bus_a.err_illegal), 1);

        // Clear on the second byte of a word aborts it
        push_word(0, 12, 32'h40221234, 2);
        send(0, 6'b010000, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 26'd0);
        @(posedge clk); #1;
        t_clear = 1'b1;
        @(posedge clk); #1;
        t_clear = 1'b0;
        chk("abort_we",      32'(bus_a.mem_we), 0);
        chk("abort_wc",      32'(bus_a.word_count), 0);
        chk("abort_illegal", 32'(bus_a.err_illegal), 0);
        chk("abort_ready",   32'(bus_a.in_ready), 1);
        push_word(0, 0, 32'h6C64FFFF, 4);
        send(0, 6'b011011, 5'd3, 5'd4, 5'd0, 5'd0, 16'hFFFF, 26'd0);
        wait_cycles(4);
        chk("after_abort_wc", 32'(bus_a.word_count), 1);

        // Asynchronous reset mid-write, between clock edges
        push_word(0, 4, 32'hC0C70010, 1);
        send(0, 6'b110000, 5'd6, 5'd7, 5'd0, 5'd0, 16'h0010, 26'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we",    32'(bus_a.mem_we), 0);
        chk("arst_addr",  32'(bus_a.mem_addr), 0);
        chk("arst_wdata", 32'(bus_a.mem_wdata), 0);
        chk("arst_wc",    32'(bus_a.word_count), 0);
        chk("arst_ready", 32'(bus_a.in_ready), 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // 16-byte memory: four non-halt words fill it, fifth is refused
        push_word(1, 0,  32'h44221800, 4);
        send(1, 6'b010001, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
        push_word(1, 4,  32'h9C430004, 4);
        send(1, 6'b100111, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0004, 26'd0);
        push_word(1, 8,  32'hC422FFFE, 4);
        send(1, 6'b110001, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFE, 26'd0);
        push_word(1, 12, 32'h04010005, 4);
        send(1, 6'b000001, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0005, 26'd0);
        wait_cycles(4);
        chk("full_err",   32'(bus_b.err_full), 1);
        chk("full_done",  32'(bus_b.load_done), 1);
        chk("full_wc",    32'(bus_b.word_count), 4);
        chk("full_ready", 32'(bus_b.in_ready), 0);
        t_sel = 1; t_op = 6'b000001; t_imm = 16'h0006; t_valid = 1'b1;
        wait_cycles(8);
        t_valid = 1'b0;
        chk("fifth_refused_wc", 32'(bus_b.word_count), 4);

        // Halt in the last slot is not an overflow
        pulse_clear(1);
        chk("clr_b_full", 32'(bus_b.err_full), 0);
        chk("clr_b_done", 32'(bus_b.load_done), 0);
        push_word(1, 0,  32'h00221800, 4);
        send(1, 6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
        push_word(1, 4,  32'h40221234, 4);
        send(1, 6'b010000, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 26'd0);
        push_word(1, 8,  32'h0BFFF800, 4);
        send(1, 6'b000010, 5'd31, 5'd31, 5'd31, 5'd0, 16'd0, 26'd0);
        push_word(1, 12, 32'hFC000000, 4);
        send(1, 6'b111111, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        wait_cycles(4);
        chk("lasthalt_done", 32'(bus_b.load_done), 1);
        chk("lasthalt_full", 32'(bus_b.err_full), 0);
        chk("lasthalt_wc",   32'(bus_b.word_count), 4);

        wait_cycles(2);
        chk("queue_a_drained", 32'(q_a.size()), 0);
        chk("queue_b_drained", 32'(q_b.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the instruction memory: the CPU datapath only reads instruction memory (InsMemRW fixed to read), and this block fills it before the CPU runs.
- Accepts instruction fields (opcode, rs, rt, rd, sa, imm, target) over a valid/ready handshake and encodes them into 32-bit words.
- Writes each word big-endian, one byte per cycle, into the byte-wide instruction memory at sequential addresses.
- Stops at the halt opcode or when memory is full.

Parameters:
- MEM_BYTES, 128, instruction memory size in bytes; a multiple of 4.
- ADDR_W, 7, byte address width; must satisfy 2**ADDR_W >= MEM_BYTES.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart of a load session.
- in_valid  in  1  instruction fields are valid.
- in_ready  out  1  loader can accept fields this cycle.
- in_op  in  6  opcode.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_sa  in  5  shift amount.
- in_imm  in  16  immediate.
- in_target  in  26  jump target field, already word-address bits [27:2].
- mem_we  out  1  byte write strobe to instruction memory.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  byte data.
- word_count  out  ADDR_W-1  words fully written.
- load_done  out  1  sticky; session finished.
- err_illegal  out  1  sticky; an unsupported opcode was received.
- err_full  out  1  sticky; memory filled before halt.

Behaviour:
- Reset low (async): state=IDLE, address=0, byte index=0, word_count=0, all flags 0, mem_we=0, mem_addr=0, mem_wdata=0. in_ready reads 1 once reset releases.
- Encoding, bits [31:26]=op:
  - R-class 000000 add, 000010 sub, 010001 and, 010010 or: {op,rs,rt,rd,11'b0}.
  - Shift 011000 sll: {op,5'b0,rt,rd,sa,6'b0}.
  - I-class 000001 addi, 010000 ori, 011011 slti, 100110 sw, 100111 lw, 110000 beq, 110001 bne: {op,rs,rt,imm}.
  - J 111000: {op,target}.
  - Halt 111111: {op,26'b0}.
  - Fields unused by a class are ignored.
  - Any other opcode is illegal.
- States IDLE, WRITE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid with a legal opcode: latch the encoded word; byte index=0; go to WRITE.
  - On in_valid with an illegal opcode: set err_illegal; drop the word; stay in IDLE. The address does not advance.
- WRITE:
  - in_ready=0, mem_we=1 for exactly 4 consecutive cycles.
  - Bytes go out as word[31:24], [23:16], [15:8], [7:0] at address+0..+3.
  - After byte 3: address+=4 and word_count+=1.
    - If the word was halt: go to DONE, load_done=1.
    - Else if the new address equals MEM_BYTES (full): go to DONE, load_done=1, err_full=1.
    - Otherwise return to IDLE.
  - Halt written into the last slot gives err_full=0.
- Throughput: one word per 5 cycles (accept cycle plus 4 byte writes). The first byte is written on the cycle after acceptance.
- DONE: in_ready=0, mem_we=0. Hold all outputs until clear or Reset.
- clear:
  - Has priority over every transition.
  - Next state is IDLE with address, word_count and all flags zeroed, and mem_we=0 from the next cycle.
  - clear during WRITE aborts the word. Bytes already written stay in memory and are not counted.
- mem_addr and mem_wdata are don't-care while mem_we=0; they hold their last values.

Decomposition:
- Shared package holds:
  - opcode constants: OP_ADD, OP_ADDI, OP_SUB, OP_ORI, OP_AND, OP_OR, OP_SLL, OP_SLTI, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_J, OP_HALT.
  - instruction field bit positions.
  - a state enum type.
- The same opcode constants are shared with the control unit, so decoder and loader cannot diverge.
- One sub-module, instr_word_encoder: purely combinational fields-to-word plus a legal flag.
- The FSM, address counter and byte sequencer live in instr_mem_loader.

Test Plan:
- addi rs=0 rt=1 imm=8 -> word 0x04010008; bytes 04,01,00,08 at addr 0..3 on 4 consecutive mem_we cycles; word_count=1; back in IDLE.
- add rs=1 rt=2 rd=3, then sll rt=1 rd=2 sa=2, then j target=0x000004, then halt:
  - words 0x00221800, 0x60011080, 0xE0000004, 0xFC000000 at byte addr 0, 4, 8, 12.
  - load_done=1, word_count=4; in_ready stays 0 afterwards.
- in_op=6'b101010 with in_valid -> err_illegal=1, no mem_we, address unchanged; the following addi is written at address 0.
- MEM_BYTES=16, five non-halt words offered -> 4 words written (addr 0..15), err_full=1, load_done=1; the fifth word is never accepted.
- clear asserted on the 2nd byte of a word -> mem_we=0 next cycle, word_count=0, flags 0; the next accepted word is written at address 0.
- Reset pulsed low mid-WRITE, asynchronously between clock edges -> outputs go to reset values immediately, without waiting for a clock edge.
